// File: rtl/select_pkg.sv
// Shared constants and state encoding for the part-select reader/writer pair.
// Holds word/nibble/index/count widths, the overflow index limit and the FSM enum.
package select_pkg;
  localparam int WORD_W    = 16;
  localparam int NIB_W     = 4;
  localparam int IDX_W     = 4;
  localparam int CNT_W     = 5;
  localparam int OVF_LIMIT = 12;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_e;
endpackage

// File: rtl/part_insert.sv
// Combinational nibble insert: word_i with bits [idx_i +: NIB_W] replaced by nib_i.
// Ports: word_i/idx_i/nib_i in; mask_o, word_o, ovf_o out. Macro: PART_INSERT_WRAP_EN.
module part_insert
  import select_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [NIB_W-1:0]  nib_i,
  output logic [WORD_W-1:0] mask_o,
  output logic [WORD_W-1:0] word_o,
  output logic              ovf_o
);
  logic [2*WORD_W-1:0] wmask;
  logic [2*WORD_W-1:0] wdata;
  logic [WORD_W-1:0]   data;

  always_comb begin
    wmask = (2*WORD_W)'({NIB_W{1'b1}}) << idx_i;
    wdata = (2*WORD_W)'(nib_i) << idx_i;
`ifdef PART_INSERT_WRAP_EN
    // Bits pushed past the top fold back onto the bottom of the word.
    mask_o = wmask[WORD_W-1:0] | wmask[2*WORD_W-1:WORD_W];
    data   = wdata[WORD_W-1:0] | wdata[2*WORD_W-1:WORD_W];
`else
    mask_o = wmask[WORD_W-1:0];
    data   = wdata[WORD_W-1:0];
`endif
    word_o = (word_i & ~mask_o) | (data & mask_o);
    ovf_o  = idx_i > IDX_W'(OVF_LIMIT);
  end
endmodule

// File: rtl/part_insert_writer.sv
// Assembles a 16-bit word from indexed nibble beats and emits it on a handshake.
// Ports: clk, rst_n; wr_valid/ready/idx/data/last in; out_valid/ready/word/count/ovf out.
// Macro: PART_INSERT_WRAP_EN (wrap out-of-range nibble bits instead of dropping).
module part_insert_writer
  import select_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [NIB_W-1:0]  wr_data,
  input  logic              wr_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);
  state_e             state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [WORD_W-1:0]  ins_mask;
  logic [WORD_W-1:0]  ins_word;
  logic               ins_ovf;
  logic               acc;

  part_insert u_ins (
    .word_i (word_q),
    .idx_i  (wr_idx),
    .nib_i  (wr_data),
    .mask_o (ins_mask),
    .word_o (ins_word),
    .ovf_o  (ins_ovf)
  );

  assign wr_ready  = (state_q == FILL);
  assign out_valid = (state_q == EMIT);
  assign out_word  = word_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;
  assign acc       = wr_valid & wr_ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      FILL: begin
        if (acc) begin
          word_d = ins_word;
          cnt_d  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          ovf_d  = ovf_q | ins_ovf;
          if (wr_last) state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          state_d = FILL;
          word_d  = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      word_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_part_insert_writer.sv
// Self-checking bench for part_insert_writer: vector table, corner sequences,
// and randomized words against a bit-level reference model.
module tb_part_insert_writer;
  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_idx;
  logic [3:0]  wr_data;
  logic        wr_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_word;
  logic [4:0]  out_count;
  logic        out_ovf;

  int n_vec;
  int n_miss;

  part_insert_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .wr_last   (wr_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          nb;
    logic [3:0]  idx [4];
    logic [3:0]  dat [4];
    logic [15:0] exp_w;
    int          exp_c;
    logic        exp_o;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " wr_ready"}, 32'(wr_ready), 32'd1);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " word"}, 32'(out_word), 32'h0);
    chk({tag, " count"}, 32'(out_count), 32'd0);
    chk({tag, " ovf"}, 32'(out_ovf), 32'd0);
  endtask

  // Called at a negedge; leaves at the negedge after the accepting edge.
  task automatic beat(input logic [3:0] idx, input logic [3:0] dat,
                      input logic last);
    wr_valid = 1'b1;
    wr_idx   = idx;
    wr_data  = dat;
    wr_last  = last;
    chk("beat wr_ready", 32'(wr_ready), 32'd1);
    chk("beat out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  // Checks the emitted word, stalls with junk on wr_*, then handshakes.
  task automatic drain(input string tag, input logic [15:0] w,
                       input int c, input logic o, input int stall);
    for (int s = 0; s <= stall; s++) begin
      chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " wr_ready"}, 32'(wr_ready), 32'd0);
      chk({tag, " word"}, 32'(out_word), 32'(w));
      chk({tag, " count"}, 32'(out_count), 32'(c));
      chk({tag, " ovf"}, 32'(out_ovf), 32'(o));
      if (s < stall) begin
        wr_valid = 1'b1;
        wr_idx   = 4'($urandom_range(0, 15));
        wr_data  = 4'($urandom_range(0, 15));
        wr_last  = 1'($urandom_range(0, 1));
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
      end
    end
    wr_valid  = 1'b0;
    wr_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk_idle({tag, " after"});
  endtask

  // Reference: write each nibble bit at its absolute position.
  function automatic logic [15:0] ref_ins(input logic [15:0] w,
                                          input int idx,
                                          input logic [3:0] d);
    logic [15:0] r;
    r = w;
    for (int k = 0; k < 4; k++) begin
      int p;
      p = idx + k;
`ifdef PART_INSERT_WRAP_EN
      p = p % 16;
`endif
      if (p < 16) r[p] = d[k];
    end
    return r;
  endfunction

  initial begin
    n_vec = 0;
    n_miss = 0;
    rst_n = 1'b0;
    wr_valid = 1'b0;
    wr_idx = '0;
    wr_data = '0;
    wr_last = 1'b0;
    out_ready = 1'b0;

    vt[0].nb = 2;
    vt[0].idx[0] = 4'd0; vt[0].dat[0] = 4'hA;
    vt[0].idx[1] = 4'd4; vt[0].dat[1] = 4'h5;
    vt[0].exp_w = 16'h005A; vt[0].exp_c = 2; vt[0].exp_o = 1'b0;

    vt[1].nb = 2;
    vt[1].idx[0] = 4'd2; vt[1].dat[0] = 4'hF;
    vt[1].idx[1] = 4'd4; vt[1].dat[1] = 4'h0;
    vt[1].exp_w = 16'h000C; vt[1].exp_c = 2; vt[1].exp_o = 1'b0;

    vt[2].nb = 1;
    vt[2].idx[0] = 4'd14; vt[2].dat[0] = 4'hF;
`ifdef PART_INSERT_WRAP_EN
    vt[2].exp_w = 16'hC003;
`else
    vt[2].exp_w = 16'hC000;
`endif
    vt[2].exp_c = 1; vt[2].exp_o = 1'b1;

    vt[3].nb = 3;
    vt[3].idx[0] = 4'd12; vt[3].dat[0] = 4'h9;
    vt[3].idx[1] = 4'd8;  vt[3].dat[1] = 4'h6;
    vt[3].idx[2] = 4'd1;  vt[3].dat[2] = 4'h7;
    vt[3].exp_w = 16'h960E; vt[3].exp_c = 3; vt[3].exp_o = 1'b0;

    vt[4].nb = 2;
    vt[4].idx[0] = 4'd0;  vt[4].dat[0] = 4'h1;
    vt[4].idx[1] = 4'd13; vt[4].dat[1] = 4'hB;
`ifdef PART_INSERT_WRAP_EN
    vt[4].exp_w = 16'h6001;
`else
    vt[4].exp_w = 16'h6001;
`endif
    vt[4].exp_c = 2; vt[4].exp_o = 1'b1;

    #12;
    chk_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post-reset");

    for (int v = 0; v < 5; v++) begin
      for (int b = 0; b < vt[v].nb; b++)
        beat(vt[v].idx[b], vt[v].dat[b], b == vt[v].nb - 1);
      drain($sformatf("vec%0d", v), vt[v].exp_w, vt[v].exp_c,
            vt[v].exp_o, 0);
    end

    // Backpressure: 3 stalled cycles with wr_valid high.
    beat(4'd0, 4'h7, 1'b1);
    drain("bp", 16'h0007, 1, 1'b0, 3);
    beat(4'd8, 4'h1, 1'b1);
    drain("bp-next", 16'h0100, 1, 1'b0, 0);

    // Saturation: 35 beats at idx 0.
    for (int i = 0; i < 35; i++)
      beat(4'd0, 4'(i), i == 34);
    drain("sat", 16'h0002, 31, 1'b0, 0);

    // Reset mid-fill, checked before any clock edge.
    beat(4'd0, 4'h1, 1'b0);
    beat(4'd4, 4'h2, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_idle("rst-fill");
    @(negedge clk);
    rst_n = 1'b1;
    beat(4'd8, 4'h3, 1'b1);
    drain("rst-next", 16'h0300, 1, 1'b0, 0);

    // Reset while a word is pending.
    beat(4'd4, 4'hE, 1'b1);
    chk("pend valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_idle("rst-emit");
    @(negedge clk);
    rst_n = 1'b1;

    // Random words against the reference model.
    for (int w = 0; w < 40; w++) begin
      logic [15:0] mw;
      int          mc;
      logic        mo;
      int          nb;
      mw = '0;
      mc = 0;
      mo = 1'b0;
      nb = $urandom_range(1, 8);
      for (int b = 0; b < nb; b++) begin
        logic [3:0] ri;
        logic [3:0] rd;
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          wr_idx  = 4'($urandom_range(0, 15));
          wr_data = 4'($urandom_range(0, 15));
          @(posedge clk);
          @(negedge clk);
        end
        ri = 4'($urandom_range(0, 15));
        rd = 4'($urandom_range(0, 15));
        beat(ri, rd, b == nb - 1);
        mw = ref_ins(mw, int'(ri), rd);
        mc = (mc < 31) ? mc + 1 : 31;
        if (int'(ri) > 12) mo = 1'b1;
      end
      drain($sformatf("rnd%0d", w), mw, mc, mo, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
